// File: rtl/xy_buffered_router.sv
// 5-port XY mesh router: per-input FIFOs, dimension-ordered routing, per-output round-robin, registered outputs.
// 2-cycle input-to-output latency; in_ready depends only on FIFO fullness, and a stalled output holds its flit.

module xy_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
endmodule

module xy_buffered_router #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int COORD_W    = 4,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5*DATA_W-1:0] in_data,
  input  logic [4:0]        in_valid,
  output logic [4:0]        in_ready,
  output logic [5*DATA_W-1:0] out_data,
  output logic [4:0]        out_valid,
  input  logic [4:0]        out_ready
);
  localparam logic [2:0] P_N = 3'd0, P_S = 3'd1, P_E = 3'd2, P_W = 3'd3, P_L = 3'd4;
  localparam logic [COORD_W-1:0] MY_XC = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_YC = COORD_W'(MY_Y);

  logic [DATA_W-1:0] head [5];
  logic [4:0]        empty, full, push, pop;
  logic [2:0]        route [5];
  logic [4:0]        req [5];
  logic [4:0]        gnt_vld;
  logic [2:0]        gnt_idx [5];
  logic [DATA_W-1:0] gnt_dat [5];

  logic [DATA_W-1:0] out_data_q [5], out_data_d [5];
  logic [4:0]        out_valid_q, out_valid_d;
  logic [2:0]        rr_q [5], rr_d [5];

  assign in_ready = ~full & {5{~reset}};
  assign push     = in_valid & in_ready;

  for (genvar p = 0; p < 5; p++) begin : g_port
    xy_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (push[p]),
      .pop_i  (pop[p]),
      .wdata_i(in_data[p*DATA_W +: DATA_W]),
      .rdata_o(head[p]),
      .full_o (full[p]),
      .empty_o(empty[p])
    );
    assign out_data[p*DATA_W +: DATA_W] = out_data_q[p];
  end

  assign out_valid = out_valid_q;

  always_comb begin
    logic [COORD_W-1:0] dx, dy;
    for (int i = 0; i < 5; i++) begin
      dx = head[i][DATA_W-1 -: COORD_W];
      dy = head[i][DATA_W-COORD_W-1 -: COORD_W];
      if (dx > MY_XC)      route[i] = P_E;
      else if (dx < MY_XC) route[i] = P_W;
      else if (dy > MY_YC) route[i] = P_N;
      else if (dy < MY_YC) route[i] = P_S;
      else                 route[i] = P_L;
    end
  end

  // Search from rr[o] upward; each input has one head so at most one output grants it.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] cand;
    pop = '0;
    for (int o = 0; o < 5; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      gnt_dat[o] = '0;
      for (int i = 0; i < 5; i++) req[o][i] = !empty[i] && (route[i] == 3'(o));
      for (int k = 0; k < 5; k++) begin
        sum  = {1'b0, rr_q[o]} + 4'(k);
        cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
        if (!gnt_vld[o] && (!out_valid_q[o] || out_ready[o]) && req[o][cand]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = cand;
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (gnt_vld[o] && gnt_idx[o] == 3'(i)) begin
          gnt_dat[o] = head[i];
          pop[i]     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < 5; o++) begin
      out_data_d[o]  = out_data_q[o];
      out_valid_d[o] = out_valid_q[o];
      rr_d[o]        = rr_q[o];
      if (gnt_vld[o]) begin
        out_data_d[o]  = gnt_dat[o];
        out_valid_d[o] = 1'b1;
        rr_d[o]        = (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
      end else if (out_ready[o]) begin
        out_valid_d[o] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= '0;
      for (int o = 0; o < 5; o++) begin
        out_data_q[o] <= '0;
        rr_q[o]       <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      for (int o = 0; o < 5; o++) begin
        out_data_q[o] <= out_data_d[o];
        rr_q[o]       <= rr_d[o];
      end
    end
  end
endmodule

// File: tb/tb_xy_buffered_router.sv
// Scoreboard bench for xy_buffered_router at node (1,1) with 16-bit flits {dx[4], dy[4], payload[8]}.
module tb_xy_buffered_router;
  localparam int DW = 16;
  localparam int N = 0, S = 1, E = 2, W = 3, L = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5*DW-1:0] in_data = '0;
  logic [4:0]    in_valid = '0;
  logic [4:0]    in_ready;
  logic [5*DW-1:0] out_data;
  logic [4:0]    out_valid;
  logic [4:0]    out_ready = 5'b11111;

  int            n_tests = 0;
  int            n_fail = 0;
  int            dst_lane [5];
  logic [DW-1:0] exp_q [5][$];

  xy_buffered_router #(.DATA_W(DW), .FIFO_DEPTH(4), .COORD_W(4), .MY_X(1), .MY_Y(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int dx, input int dy, input int pl);
    return {4'(dx), 4'(dy), 8'(pl)};
  endfunction

  // Accepted flits are queued against the output the bench expects them on.
  always @(negedge clk) begin
    if (!reset) begin
      for (int p = 0; p < 5; p++)
        if (in_valid[p] && in_ready[p]) exp_q[dst_lane[p]].push_back(in_data[p*DW +: DW]);
      for (int o = 0; o < 5; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          if (exp_q[o].size() == 0) chk($sformatf("spurious_out%0d", o), 32'(out_valid[o]), 32'd0);
          else chk($sformatf("out%0d_data", o), 32'(out_data[o*DW +: DW]), 32'(exp_q[o].pop_front()));
        end
      end
    end
  end

  task automatic send(input int p, input logic [DW-1:0] f, input int dst, input int budget,
                      output bit acc);
    in_data[p*DW +: DW] = f;
    dst_lane[p] = dst;
    in_valid[p] = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < budget && !acc; c++) begin
      @(negedge clk);
      acc = in_ready[p];
      @(posedge clk);
      #1;
    end
    in_valid[p] = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int sw_dx [5] = '{0, 1, 1, 1, 2};
    int sw_dy [5] = '{1, 2, 0, 1, 0};
    int sw_po [5] = '{W, N, S, L, E};

    for (int p = 0; p < 5; p++) dst_lane[p] = 0;

    // Reset state
    tick(2);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1f);
    chk("post_rst_out_data", 32'(out_data[E*DW +: DW]), 32'h0);
    @(posedge clk); #1;

    // Single flit L -> E, 2-cycle latency
    send(L, mk(3, 1, 8'hA5), E, 4, acc);
    chk("single_acc", 32'(acc), 32'd1);
    @(negedge clk);
    chk("single_lat1", 32'(out_valid), 32'h00);
    @(negedge clk);
    chk("single_lat2", 32'(out_valid), 32'h04);
    tick(2);

    // Routing sweep from L; (2,0) must go E (X before Y)
    for (int k = 0; k < 5; k++) send(L, mk(sw_dx[k], sw_dy[k], 8'h10 + k), sw_po[k], 4, acc);
    tick(4);

    // Contention into E from N,S,W,L, twice: second round also shows rr[E] back at 0
    for (int r = 0; r < 2; r++) begin
      in_data[N*DW +: DW] = mk(3, 0, 8'h20 + r); dst_lane[N] = E;
      in_data[S*DW +: DW] = mk(2, 5, 8'h30 + r); dst_lane[S] = E;
      in_data[W*DW +: DW] = mk(4, 1, 8'h40 + r); dst_lane[W] = E;
      in_data[L*DW +: DW] = mk(9, 9, 8'h50 + r); dst_lane[L] = E;
      in_valid = 5'b11011;
      @(posedge clk); #1;
      in_valid = '0;
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("cont_vld_r%0d_c%0d", r, c), 32'(out_valid[E]), 32'd1);
      end
      @(negedge clk);
      chk("cont_idle", 32'(out_valid[E]), 32'd0);
      @(posedge clk); #1;
    end

    // Backpressure: E stalled, 6 flits offered on W
    out_ready[E] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(W, mk(5, 1, 8'h60 + k), E, 6, acc);
      chk($sformatf("bp_acc%0d", k), 32'(acc), 32'd1);
    end
    send(W, mk(5, 1, 8'h65), E, 4, acc);
    chk("bp_reject", 32'(acc), 32'd0);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready[W]), 32'd0);
    chk("bp_hold_vld", 32'(out_valid[E]), 32'd1);
    chk("bp_hold_dat", 32'(out_data[E*DW +: DW]), 32'(mk(5, 1, 8'h60)));
    @(posedge clk); #1;
    out_ready[E] = 1'b1;
    tick(8);
    chk("bp_drained", 32'(exp_q[E].size()), 32'd0);

    // FIFO wrap: 12 flits L -> N back to back
    dst_lane[L] = N;
    for (int k = 0; k < 12; k++) begin
      in_data[L*DW +: DW] = mk(1, 7, 8'h80 + k);
      in_valid[L] = 1'b1;
      @(negedge clk);
      chk($sformatf("wrap_rdy%0d", k), 32'(in_ready[L]), 32'd1);
      @(posedge clk); #1;
    end
    in_valid[L] = 1'b0;
    tick(4);
    chk("wrap_drained", 32'(exp_q[N].size()), 32'd0);

    // Reset mid-stream with 3 flits held
    out_ready[N] = 1'b0;
    for (int k = 0; k < 3; k++) send(L, mk(1, 3, 8'hC0 + k), N, 4, acc);
    tick(1);
    @(negedge clk);
    chk("mid_held_vld", 32'(out_valid[N]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int o = 0; o < 5; o++) exp_q[o].delete();
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'h0);
    chk("mid_in_ready", 32'(in_ready), 32'h1f);
    @(posedge clk); #1;
    out_ready = 5'b11111;
    tick(8);

    for (int o = 0; o < 5; o++) chk($sformatf("final_q%0d", o), 32'(exp_q[o].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
